// File: rtl/uart_frac_baud_gen.sv
// Fractional UART baud generator: oversample, bit and mid-bit ticks from one clock.
// Defining UART_BAUD_CLKOUT_EN adds the baud_clk debug square-wave output.
module uart_frac_baud_gen #(
  parameter int unsigned DIV_W  = 16,
  parameter int unsigned FRAC_W = 4,
  parameter int unsigned OVS_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              restart,
  input  logic [DIV_W-1:0]  div_int,
  input  logic [FRAC_W-1:0] div_frac,
  input  logic [OVS_W-1:0]  ovs_ratio,
  output logic              os_tick,
  output logic              bit_tick,
  output logic              mid_tick,
  output logic              cfg_err
`ifdef UART_BAUD_CLKOUT_EN
  ,
  output logic              baud_clk
`endif
);

  localparam int unsigned CNT_W = DIV_W + 1;
  localparam int unsigned ACC_W = FRAC_W + 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;

  logic [1:0]        state, state_nxt;
  logic              en_d;
  logic              armed;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [FRAC_W-1:0] acc, acc_nxt;
  logic [OVS_W-1:0]  os_idx, os_idx_nxt;
  logic [DIV_W-1:0]  sh_div, sh_div_nxt;
  logic [FRAC_W-1:0] sh_frac, sh_frac_nxt;
  logic [OVS_W-1:0]  sh_ovs, sh_ovs_nxt;
  logic              os_tick_nxt, bit_tick_nxt, mid_tick_nxt, cfg_err_nxt;

  logic              start_c;
  logic              in_err_c;
  logic [ACC_W-1:0]  acc_sum_c;
  logic [CNT_W-1:0]  period_c;
  logic              period_end_c;
  logic [OVS_W-1:0]  ovs_last_c;
  logic [OVS_W-1:0]  ovs_mid_c;

  // Reset disarms edge detection until en has been seen low.
  assign start_c      = armed & en & (~en_d | restart);
  assign in_err_c     = (div_int < DIV_W'(2)) | (ovs_ratio < OVS_W'(4));
  assign acc_sum_c    = {1'b0, acc} + {1'b0, sh_frac};
  assign period_c     = {1'b0, sh_div} + CNT_W'(acc_sum_c[FRAC_W]);
  assign period_end_c = (state == ST_RUN) && (cnt == period_c);
  assign ovs_last_c   = sh_ovs - OVS_W'(1);
  assign ovs_mid_c    = (sh_ovs >> 1) - OVS_W'(1);

  // Next-state and tick decode.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    acc_nxt      = acc;
    os_idx_nxt   = os_idx;
    sh_div_nxt   = sh_div;
    sh_frac_nxt  = sh_frac;
    sh_ovs_nxt   = sh_ovs;
    os_tick_nxt  = 1'b0;
    bit_tick_nxt = 1'b0;
    mid_tick_nxt = 1'b0;

    if (!en) begin
      state_nxt  = ST_IDLE;
      cnt_nxt    = '0;
      acc_nxt    = '0;
      os_idx_nxt = '0;
    end else if (start_c) begin
      sh_div_nxt  = div_int;
      sh_frac_nxt = div_frac;
      sh_ovs_nxt  = ovs_ratio;
      os_idx_nxt  = '0;
      if (in_err_c) begin
        state_nxt = ST_HALT;
        cnt_nxt   = '0;
        acc_nxt   = '0;
      end else begin
        state_nxt = ST_RUN;
        cnt_nxt   = CNT_W'(1);
        acc_nxt   = div_frac;
      end
    end else begin
      case (state)
        ST_RUN: begin
          if (period_end_c) begin
            os_tick_nxt  = 1'b1;
            bit_tick_nxt = (os_idx == ovs_last_c);
            mid_tick_nxt = (os_idx == ovs_mid_c);
            cnt_nxt      = CNT_W'(1);
            acc_nxt      = acc_sum_c[FRAC_W-1:0];
            os_idx_nxt   = (os_idx >= ovs_last_c) ? OVS_W'(0) : os_idx + OVS_W'(1);
            sh_div_nxt   = div_int;
            sh_frac_nxt  = div_frac;
            sh_ovs_nxt   = ovs_ratio;
            // New config lands here; an invalid one halts after this last tick.
            if (in_err_c) begin
              state_nxt  = ST_HALT;
              cnt_nxt    = '0;
              acc_nxt    = '0;
              os_idx_nxt = '0;
            end
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
        default: begin
          cnt_nxt    = '0;
          acc_nxt    = '0;
          os_idx_nxt = '0;
        end
      endcase
    end

    cfg_err_nxt = (state_nxt == ST_HALT) | ((state_nxt == ST_IDLE) & in_err_c);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      en_d     <= 1'b0;
      armed    <= 1'b0;
      cnt      <= '0;
      acc      <= '0;
      os_idx   <= '0;
      sh_div   <= '0;
      sh_frac  <= '0;
      sh_ovs   <= '0;
      os_tick  <= 1'b0;
      bit_tick <= 1'b0;
      mid_tick <= 1'b0;
      cfg_err  <= 1'b0;
    end else begin
      state    <= state_nxt;
      en_d     <= en;
      armed    <= armed | ~en;
      cnt      <= cnt_nxt;
      acc      <= acc_nxt;
      os_idx   <= os_idx_nxt;
      sh_div   <= sh_div_nxt;
      sh_frac  <= sh_frac_nxt;
      sh_ovs   <= sh_ovs_nxt;
      os_tick  <= os_tick_nxt;
      bit_tick <= bit_tick_nxt;
      mid_tick <= mid_tick_nxt;
      cfg_err  <= cfg_err_nxt;
    end
  end

`ifdef UART_BAUD_CLKOUT_EN
  logic baud_clk_nxt;

  // High from bit end to mid-bit, low for the second half.
  always_comb begin
    baud_clk_nxt = baud_clk;
    if (state_nxt != ST_RUN) begin
      baud_clk_nxt = 1'b0;
    end else if (bit_tick_nxt) begin
      baud_clk_nxt = 1'b1;
    end else if (mid_tick_nxt) begin
      baud_clk_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      baud_clk <= 1'b0;
    end else begin
      baud_clk <= baud_clk_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_uart_frac_baud_gen.sv
// Bench for uart_frac_baud_gen: tick times checked against a period-list reference model.
module tb_uart_frac_baud_gen;

  localparam int unsigned FRAC_MOD = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        restart;
  logic [15:0] div_int;
  logic [3:0]  div_frac;
  logic [4:0]  ovs_ratio;
  logic        os_tick, bit_tick, mid_tick, cfg_err;
`ifdef UART_BAUD_CLKOUT_EN
  logic        baud_clk;
`endif

  uart_frac_baud_gen dut (
    .clk(clk), .rst(rst), .en(en), .restart(restart),
    .div_int(div_int), .div_frac(div_frac), .ovs_ratio(ovs_ratio),
    .os_tick(os_tick), .bit_tick(bit_tick), .mid_tick(mid_tick), .cfg_err(cfg_err)
`ifdef UART_BAUD_CLKOUT_EN
    , .baud_clk(baud_clk)
`endif
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  bit          mon_en = 1'b0;
  int unsigned act_t[$];
  bit          act_o[$], act_b[$], act_m[$];
  int unsigned exp_t[$];
  bit          exp_b[$], exp_m[$];

  // Record every cycle in which any tick output is high.
  always @(negedge clk) begin
    if (mon_en && (os_tick || bit_tick || mid_tick)) begin
      act_t.push_back(cyc);
      act_o.push_back(os_tick);
      act_b.push_back(bit_tick);
      act_m.push_back(mid_tick);
    end
  end

  // Expected ticks for a run started at edge t0, ending before edge t_stop.
  // div_b replaces div_a for periods beginning at or after edge tc.
  function automatic void model_add(int unsigned t0, int unsigned t_stop, int unsigned div_a,
                                    int unsigned div_b, int unsigned tc, int unsigned frac,
                                    int unsigned ovs);
    int unsigned acc, t, idx, sdiv;
    acc  = frac;
    t    = t0;
    idx  = 0;
    sdiv = (t0 >= tc) ? div_b : div_a;
    for (int k = 0; k < 100000; k++) begin
      t += sdiv + (((acc + frac) >= FRAC_MOD) ? 1 : 0);
      if (t >= t_stop) break;
      exp_t.push_back(t);
      exp_b.push_back(idx == ovs - 1);
      exp_m.push_back(idx == ovs / 2 - 1);
      acc  = (acc + frac) % FRAC_MOD;
      idx  = (idx + 1) % ovs;
      sdiv = (t >= tc) ? div_b : div_a;
    end
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic go_idle();
    en = 1'b0;
    restart = 1'b0;
    step(3);
  endtask

  task automatic start_capture();
    act_t.delete(); act_o.delete(); act_b.delete(); act_m.delete();
    exp_t.delete(); exp_b.delete(); exp_m.delete();
    mon_en = 1'b1;
  endtask

  task automatic stop_capture(output int unsigned last);
    mon_en = 1'b0;
    last = cyc - 1;
  endtask

  task automatic start_en(output int unsigned t0);
    @(posedge clk);
    #1;
    en = 1'b1;
    t0 = cyc + 1;
  endtask

  task automatic set_cfg(input int unsigned d, input int unsigned f, input int unsigned o);
    div_int   = 16'(d);
    div_frac  = 4'(f);
    ovs_ratio = 5'(o);
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; restart = 1'b0;
    set_cfg(10, 0, 16);
    step(3);
    @(negedge clk);
    checks++;
    if ({os_tick, bit_tick, mid_tick, cfg_err} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_outputs got %b want 0000", {os_tick, bit_tick, mid_tick, cfg_err});
    end
`ifdef UART_BAUD_CLKOUT_EN
    checks++;
    if (baud_clk !== 1'b0) begin
      errors++;
      $display("FAIL reset_baud_clk got %b want 0", baud_clk);
    end
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(3);
  endtask

  task automatic test_basic();
    int unsigned t0, last;
    int fb, fm;
    go_idle();
    set_cfg(10, 0, 16);
    start_capture();
    start_en(t0);
    step(340);
    stop_capture(last);
    model_add(t0, last + 1, 10, 10, 0, 0, 16);
    checks++;
    if (act_t.size() != exp_t.size()) begin
      errors++;
      $display("FAIL basic tick_count got %0d want %0d", act_t.size(), exp_t.size());
    end
    for (int i = 0; i < act_t.size() && i < exp_t.size(); i++) begin
      checks++;
      if ({act_t[i], act_o[i], act_b[i], act_m[i]} !== {exp_t[i], 1'b1, exp_b[i], exp_m[i]}) begin
        errors++;
        $display("FAIL basic tick%0d got t=%0d o=%0b b=%0b m=%0b want t=%0d b=%0b m=%0b",
                 i, act_t[i], act_o[i], act_b[i], act_m[i], exp_t[i], exp_b[i], exp_m[i]);
      end
    end
    fb = -1; fm = -1;
    foreach (act_t[i]) begin
      if (act_b[i] && fb < 0) fb = int'(act_t[i] - t0);
      if (act_m[i] && fm < 0) fm = int'(act_t[i] - t0);
    end
    checks++;
    if (fb !== 160) begin
      errors++;
      $display("FAIL basic first_bit_tick got %0d want 160", fb);
    end
    checks++;
    if (fm !== 80) begin
      errors++;
      $display("FAIL basic first_mid_tick got %0d want 80", fm);
    end
  endtask

  task automatic test_frac();
    int unsigned t0, last;
    int unsigned bt[$];
    go_idle();
    set_cfg(10, 8, 16);
    start_capture();
    start_en(t0);
    step(4 * 168 + 20);
    stop_capture(last);
    model_add(t0, last + 1, 10, 10, 0, 8, 16);
    checks++;
    if (act_t.size() != exp_t.size()) begin
      errors++;
      $display("FAIL frac tick_count got %0d want %0d", act_t.size(), exp_t.size());
    end
    for (int i = 0; i < act_t.size() && i < exp_t.size(); i++) begin
      checks++;
      if ({act_t[i], act_o[i], act_b[i], act_m[i]} !== {exp_t[i], 1'b1, exp_b[i], exp_m[i]}) begin
        errors++;
        $display("FAIL frac tick%0d got t=%0d o=%0b b=%0b m=%0b want t=%0d b=%0b m=%0b",
                 i, act_t[i], act_o[i], act_b[i], act_m[i], exp_t[i], exp_b[i], exp_m[i]);
      end
    end
    bt.push_back(t0);
    foreach (act_t[i]) if (act_b[i]) bt.push_back(act_t[i]);
    checks++;
    if (bt.size() != 5) begin
      errors++;
      $display("FAIL frac bit_tick_count got %0d want 4", bt.size() - 1);
    end
    for (int i = 1; i < bt.size(); i++) begin
      checks++;
      if (bt[i] - bt[i-1] !== 168) begin
        errors++;
        $display("FAIL frac bit_spacing%0d got %0d want 168", i, bt[i] - bt[i-1]);
      end
    end
  endtask

  task automatic test_cfg_err();
    int unsigned t0, last;
    go_idle();
    set_cfg(1, 0, 16);
    step(3);
    @(negedge clk);
    checks++;
    if (cfg_err !== 1'b1) begin
      errors++;
      $display("FAIL cfg_idle_div1 got %b want 1", cfg_err);
    end
    start_capture();
    start_en(t0);
    step(1000);
    @(negedge clk);
    checks++;
    if (cfg_err !== 1'b1) begin
      errors++;
      $display("FAIL cfg_run_div1 got %b want 1", cfg_err);
    end
    set_cfg(10, 0, 16);
    step(30);
    @(negedge clk);
    checks++;
    if (cfg_err !== 1'b1) begin
      errors++;
      $display("FAIL cfg_halt_sticky got %b want 1", cfg_err);
    end
    step(1);
    stop_capture(last);
    checks++;
    if (act_t.size() != 0) begin
      errors++;
      $display("FAIL cfg_div1_ticks got %0d want 0", act_t.size());
    end
    go_idle();
    set_cfg(10, 0, 3);
    step(3);
    @(negedge clk);
    checks++;
    if (cfg_err !== 1'b1) begin
      errors++;
      $display("FAIL cfg_idle_ovs3 got %b want 1", cfg_err);
    end
    start_capture();
    start_en(t0);
    step(300);
    stop_capture(last);
    checks++;
    if (act_t.size() != 0) begin
      errors++;
      $display("FAIL cfg_ovs3_ticks got %0d want 0", act_t.size());
    end
    go_idle();
    set_cfg(10, 0, 16);
    step(3);
    start_capture();
    start_en(t0);
    step(400);
    @(negedge clk);
    checks++;
    if (cfg_err !== 1'b0) begin
      errors++;
      $display("FAIL cfg_recovered got %b want 0", cfg_err);
    end
    step(1);
    stop_capture(last);
    model_add(t0, last + 1, 10, 10, 0, 0, 16);
    checks++;
    if (act_t.size() != exp_t.size()) begin
      errors++;
      $display("FAIL cfg_resume tick_count got %0d want %0d", act_t.size(), exp_t.size());
    end
    for (int i = 0; i < act_t.size() && i < exp_t.size(); i++) begin
      checks++;
      if ({act_t[i], act_o[i], act_b[i], act_m[i]} !== {exp_t[i], 1'b1, exp_b[i], exp_m[i]}) begin
        errors++;
        $display("FAIL cfg_resume tick%0d got t=%0d o=%0b b=%0b m=%0b want t=%0d b=%0b m=%0b",
                 i, act_t[i], act_o[i], act_b[i], act_m[i], exp_t[i], exp_b[i], exp_m[i]);
      end
    end
  endtask

  task automatic test_restart_idle();
    int unsigned last;
    go_idle();
    set_cfg(10, 0, 16);
    start_capture();
    restart = 1'b1;
    step(1);
    restart = 1'b0;
    step(60);
    stop_capture(last);
    checks++;
    if (act_t.size() != 0) begin
      errors++;
      $display("FAIL restart_idle ticks got %0d want 0", act_t.size());
    end
  endtask

  task automatic test_restart();
    int unsigned t0, t1, last;
    int fo, fb;
    go_idle();
    set_cfg(10, 0, 16);
    start_capture();
    start_en(t0);
    step(197);
    restart = 1'b1;
    t1 = cyc + 1;
    step(1);
    restart = 1'b0;
    step(360);
    stop_capture(last);
    model_add(t0, t1, 10, 10, 0, 0, 16);
    model_add(t1, last + 1, 10, 10, 0, 0, 16);
    checks++;
    if (act_t.size() != exp_t.size()) begin
      errors++;
      $display("FAIL restart tick_count got %0d want %0d", act_t.size(), exp_t.size());
    end
    for (int i = 0; i < act_t.size() && i < exp_t.size(); i++) begin
      checks++;
      if ({act_t[i], act_o[i], act_b[i], act_m[i]} !== {exp_t[i], 1'b1, exp_b[i], exp_m[i]}) begin
        errors++;
        $display("FAIL restart tick%0d got t=%0d o=%0b b=%0b m=%0b want t=%0d b=%0b m=%0b",
                 i, act_t[i], act_o[i], act_b[i], act_m[i], exp_t[i], exp_b[i], exp_m[i]);
      end
    end
    fo = -1; fb = -1;
    foreach (act_t[i]) begin
      if (act_t[i] > t1 && fo < 0) fo = int'(act_t[i] - t1);
      if (act_t[i] > t1 && act_b[i] && fb < 0) fb = int'(act_t[i] - t1);
    end
    checks++;
    if (fo !== 10) begin
      errors++;
      $display("FAIL restart first_os got %0d want 10", fo);
    end
    checks++;
    if (fb !== 160) begin
      errors++;
      $display("FAIL restart first_bit got %0d want 160", fb);
    end
  endtask

  task automatic test_div_change();
    int unsigned t0, tc, last;
    go_idle();
    set_cfg(10, 0, 16);
    start_capture();
    start_en(t0);
    step(4);
    div_int = 16'd20;
    tc = cyc + 1;
    step(120);
    stop_capture(last);
    model_add(t0, last + 1, 10, 20, tc, 0, 16);
    checks++;
    if (act_t.size() != exp_t.size()) begin
      errors++;
      $display("FAIL divchg tick_count got %0d want %0d", act_t.size(), exp_t.size());
    end
    for (int i = 0; i < act_t.size() && i < exp_t.size(); i++) begin
      checks++;
      if ({act_t[i], act_o[i], act_b[i], act_m[i]} !== {exp_t[i], 1'b1, exp_b[i], exp_m[i]}) begin
        errors++;
        $display("FAIL divchg tick%0d got t=%0d o=%0b b=%0b m=%0b want t=%0d b=%0b m=%0b",
                 i, act_t[i], act_o[i], act_b[i], act_m[i], exp_t[i], exp_b[i], exp_m[i]);
      end
    end
    checks++;
    if (act_t.size() < 2 || act_t[0] - t0 !== 10 || act_t[1] - act_t[0] !== 20) begin
      errors++;
      $display("FAIL divchg periods got first=%0d second=%0d want 10 20",
               (act_t.size() > 0) ? act_t[0] - t0 : 0,
               (act_t.size() > 1) ? act_t[1] - act_t[0] : 0);
    end
  endtask

  task automatic test_rst_mid();
    int unsigned t0, tr, last;
    go_idle();
    set_cfg(10, 0, 16);
    start_capture();
    start_en(t0);
    step(85);
    rst = 1'b1;
    tr = cyc + 1;
    step(1);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({os_tick, bit_tick, mid_tick, cfg_err} !== 4'b0000) begin
      errors++;
      $display("FAIL rstmid_outputs got %b want 0000", {os_tick, bit_tick, mid_tick, cfg_err});
    end
    step(250);
    stop_capture(last);
    model_add(t0, tr, 10, 10, 0, 0, 16);
    checks++;
    if (act_t.size() != exp_t.size() || (act_t.size() > 0 && act_t[act_t.size()-1] >= tr)) begin
      errors++;
      $display("FAIL rstmid ticks got %0d want %0d before edge %0d", act_t.size(), exp_t.size(), tr);
    end
    start_capture();
    en = 1'b0;
    step(1);
    en = 1'b1;
    t0 = cyc + 1;
    step(200);
    stop_capture(last);
    model_add(t0, last + 1, 10, 10, 0, 0, 16);
    checks++;
    if (act_t.size() != exp_t.size()) begin
      errors++;
      $display("FAIL rstmid_resume tick_count got %0d want %0d", act_t.size(), exp_t.size());
    end
    for (int i = 0; i < act_t.size() && i < exp_t.size(); i++) begin
      checks++;
      if ({act_t[i], act_o[i], act_b[i], act_m[i]} !== {exp_t[i], 1'b1, exp_b[i], exp_m[i]}) begin
        errors++;
        $display("FAIL rstmid_resume tick%0d got t=%0d o=%0b b=%0b m=%0b want t=%0d b=%0b m=%0b",
                 i, act_t[i], act_o[i], act_b[i], act_m[i], exp_t[i], exp_b[i], exp_m[i]);
      end
    end
    checks++;
    if (act_t.size() == 0 || act_t[0] - t0 !== 10) begin
      errors++;
      $display("FAIL rstmid first_os got %0d want 10", (act_t.size() > 0) ? act_t[0] - t0 : 0);
    end
  endtask

  task automatic test_random();
    int unsigned t0, t1, last, d, f, o, k;
    for (int it = 0; it < 6; it++) begin
      d = $urandom_range(12, 2);
      f = $urandom_range(15, 0);
      o = $urandom_range(10, 4);
      k = $urandom_range(300, 50);
      go_idle();
      set_cfg(d, f, o);
      start_capture();
      start_en(t0);
      step(k);
      restart = 1'b1;
      t1 = cyc + 1;
      step(1);
      restart = 1'b0;
      step(400);
      stop_capture(last);
      model_add(t0, t1, d, d, 0, f, o);
      model_add(t1, last + 1, d, d, 0, f, o);
      checks++;
      if (act_t.size() != exp_t.size()) begin
        errors++;
        $display("FAIL random%0d (d=%0d f=%0d o=%0d) tick_count got %0d want %0d",
                 it, d, f, o, act_t.size(), exp_t.size());
      end
      for (int i = 0; i < act_t.size() && i < exp_t.size(); i++) begin
        checks++;
        if ({act_t[i], act_o[i], act_b[i], act_m[i]} !== {exp_t[i], 1'b1, exp_b[i], exp_m[i]}) begin
          errors++;
          $display("FAIL random%0d tick%0d got t=%0d o=%0b b=%0b m=%0b want t=%0d b=%0b m=%0b",
                   it, i, act_t[i], act_o[i], act_b[i], act_m[i], exp_t[i], exp_b[i], exp_m[i]);
        end
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_frac();
    test_cfg_err();
    test_restart_idle();
    test_restart();
    test_div_change();
    test_rst_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
